// File: rtl/lapi_spi_sequencer.sv
// Arbitrates vec/reg update requests onto one SPI mode-0 write serialiser and
// drives each frame out on the owning peripheral's csb/sclk/mosi pins.
module lapi_spi_sequencer #(
    parameter int unsigned VEC_W       = 74,
    parameter int unsigned REG_W       = 32,
    parameter int unsigned DIV         = 2,
    parameter bit          GATE_VBLANK = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vblank,
    input  logic             vec_req,
    input  logic [VEC_W-1:0] vec_data,
    output logic             vec_ack,
    input  logic             reg_req,
    input  logic [REG_W-1:0] reg_data,
    input  logic [5:0]       reg_len,
    output logic             reg_ack,
    output logic             busy,
    output logic             vec_csb,
    output logic             vec_sclk,
    output logic             vec_mosi,
    output logic             reg_csb,
    output logic             reg_sclk,
    output logic             reg_mosi
);

    localparam int unsigned BitW    = $clog2(VEC_W + 1);
    localparam logic [7:0]  DivLoad = 8'(DIV - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    state_e            state_q, state_d;
    logic [7:0]        div_q, div_d;
    logic [BitW-1:0]   bits_q, bits_d;
    logic [VEC_W-1:0]  shreg_q, shreg_d;
    logic              high_q, high_d;
    logic              sel_vec_q, sel_vec_d;
    logic              last_vec_q, last_vec_d;
    logic              vec_csb_q, vec_sclk_q, vec_mosi_q;
    logic              reg_csb_q, reg_sclk_q, reg_mosi_q;
    logic              vec_csb_d, vec_sclk_d, vec_mosi_d;
    logic              reg_csb_d, reg_sclk_d, reg_mosi_d;

    logic              vec_elig, reg_elig, grant_vec, grant_reg, tick;
    logic              active, csb_n, sclk_n, mosi_n;
    logic [BitW-1:0]   reg_n, reg_shift;
    logic [VEC_W-1:0]  reg_load;

    assign vec_elig  = vec_req & (vblank | ~GATE_VBLANK);
    assign reg_elig  = reg_req;
    // On a tie the port not granted last wins; nothing is granted during reset.
    assign grant_vec = ~reset && (state_q == StIdle) && vec_elig && (~reg_elig || ~last_vec_q);
    assign grant_reg = ~reset && (state_q == StIdle) && reg_elig && ~grant_vec;
    assign tick      = (div_q == 8'd0);

    // Left-justify the reg payload so bit reg_n-1 lands in the shift MSB.
    assign reg_n     = (32'(reg_len) > REG_W) ? BitW'(REG_W) : BitW'(reg_len);
    assign reg_shift = BitW'(VEC_W) - reg_n;
    assign reg_load  = VEC_W'(reg_data) << reg_shift;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bits_d     = bits_q;
        shreg_d    = shreg_q;
        high_d     = high_q;
        sel_vec_d  = sel_vec_q;
        last_vec_d = last_vec_q;
        vec_ack    = 1'b0;
        reg_ack    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_vec) begin
                    vec_ack    = 1'b1;
                    sel_vec_d  = 1'b1;
                    last_vec_d = 1'b1;
                    shreg_d    = vec_data;
                    bits_d     = BitW'(VEC_W);
                    div_d      = DivLoad;
                    state_d    = StSetup;
                end else if (grant_reg) begin
                    reg_ack    = 1'b1;
                    sel_vec_d  = 1'b0;
                    last_vec_d = 1'b0;
                    shreg_d    = reg_load;
                    bits_d     = reg_n;
                    div_d      = DivLoad;
                    state_d    = (reg_n == '0) ? StGap : StSetup;
                end
            end
            StSetup: begin
                if (tick) begin
                    div_d   = DivLoad;
                    high_d  = 1'b1;
                    state_d = StShift;
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            StShift: begin
                if (tick) begin
                    div_d = DivLoad;
                    if (high_q) begin
                        high_d = 1'b0;
                        if (bits_q == BitW'(1)) begin
                            state_d = StHold;
                        end else begin
                            // Next bit is presented on the falling sclk edge.
                            bits_d  = bits_q - BitW'(1);
                            shreg_d = shreg_q << 1;
                        end
                    end else begin
                        high_d = 1'b1;
                    end
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            StHold: begin
                if (tick) begin
                    div_d   = DivLoad;
                    state_d = StGap;
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            StGap: begin
                if (tick) begin
                    state_d = StIdle;
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        active = (state_d == StSetup) || (state_d == StShift) || (state_d == StHold);
        csb_n  = ~active;
        sclk_n = (state_d == StShift) && high_d;
        mosi_n = active && shreg_d[VEC_W-1];

        vec_csb_d  = sel_vec_d ? csb_n : 1'b1;
        vec_sclk_d = sel_vec_d && sclk_n;
        vec_mosi_d = sel_vec_d && mosi_n;
        reg_csb_d  = sel_vec_d ? 1'b1 : csb_n;
        reg_sclk_d = ~sel_vec_d && sclk_n;
        reg_mosi_d = ~sel_vec_d && mosi_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            div_q      <= 8'd0;
            bits_q     <= '0;
            shreg_q    <= '0;
            high_q     <= 1'b0;
            sel_vec_q  <= 1'b0;
            last_vec_q <= 1'b0;
            vec_csb_q  <= 1'b1;
            vec_sclk_q <= 1'b0;
            vec_mosi_q <= 1'b0;
            reg_csb_q  <= 1'b1;
            reg_sclk_q <= 1'b0;
            reg_mosi_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bits_q     <= bits_d;
            shreg_q    <= shreg_d;
            high_q     <= high_d;
            sel_vec_q  <= sel_vec_d;
            last_vec_q <= last_vec_d;
            vec_csb_q  <= vec_csb_d;
            vec_sclk_q <= vec_sclk_d;
            vec_mosi_q <= vec_mosi_d;
            reg_csb_q  <= reg_csb_d;
            reg_sclk_q <= reg_sclk_d;
            reg_mosi_q <= reg_mosi_d;
        end
    end

    assign busy     = (state_q != StIdle) || vec_ack || reg_ack;
    assign vec_csb  = vec_csb_q;
    assign vec_sclk = vec_sclk_q;
    assign vec_mosi = vec_mosi_q;
    assign reg_csb  = reg_csb_q;
    assign reg_sclk = reg_sclk_q;
    assign reg_mosi = reg_mosi_q;

endmodule

// File: tb/tb_lapi_spi_sequencer.sv
// Directed bench for lapi_spi_sequencer: frame timing, bit order, arbitration,
// vblank gating, zero/clamped reg lengths and mid-frame reset.
module tb_lapi_spi_sequencer;

    localparam int Div = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vblank = 1'b0;
    logic        vec_req = 1'b0;
    logic [73:0] vec_data = '0;
    logic        reg_req = 1'b0;
    logic [31:0] reg_data = '0;
    logic [5:0]  reg_len = '0;
    logic        vec_ack, reg_ack, busy;
    logic        vec_csb, vec_sclk, vec_mosi, reg_csb, reg_sclk, reg_mosi;

    int n_vec = 0;
    int n_err = 0;

    lapi_spi_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .vblank   (vblank),
        .vec_req  (vec_req),
        .vec_data (vec_data),
        .vec_ack  (vec_ack),
        .reg_req  (reg_req),
        .reg_data (reg_data),
        .reg_len  (reg_len),
        .reg_ack  (reg_ack),
        .busy     (busy),
        .vec_csb  (vec_csb),
        .vec_sclk (vec_sclk),
        .vec_mosi (vec_mosi),
        .reg_csb  (reg_csb),
        .reg_sclk (reg_sclk),
        .reg_mosi (reg_mosi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while idle with requests set; returns just after the
    // posedge that closes the ack cycle.
    task automatic wait_ack(input int max_cyc, output bit got_vec, output bit got_reg,
                            output bit busy_at_ack, output int waited);
        got_vec = 1'b0;
        got_reg = 1'b0;
        busy_at_ack = 1'b0;
        waited = 0;
        for (int c = 0; c < max_cyc; c++) begin
            #1;
            if (vec_ack || reg_ack) begin
                got_vec = vec_ack;
                got_reg = reg_ack;
                busy_at_ack = busy;
                @(posedge clk);
                #1;
                return;
            end
            waited++;
            @(negedge clk);
        end
    endtask

    // Follows one frame from T0+1 until csb returns high (first GAP cycle).
    task automatic capture(input bit is_vec, output int low_cnt, output int rises,
                           output logic [127:0] bits, output bit other_bad);
        logic prev, csb, sclk, mosi, seen_low;
        low_cnt = 0;
        rises = 0;
        bits = '0;
        other_bad = 1'b0;
        prev = 1'b0;
        seen_low = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            csb  = is_vec ? vec_csb : reg_csb;
            sclk = is_vec ? vec_sclk : reg_sclk;
            mosi = is_vec ? vec_mosi : reg_mosi;
            if (is_vec ? (!reg_csb || reg_sclk || reg_mosi) : (!vec_csb || vec_sclk || vec_mosi))
                other_bad = 1'b1;
            if (!csb) begin
                low_cnt++;
                seen_low = 1'b1;
                if (sclk && !prev) begin
                    rises++;
                    bits = {bits[126:0], mosi};
                end
            end else if (seen_low) begin
                return;
            end
            prev = sclk;
        end
    endtask

    initial begin
        bit gv, gr, bz, ob, saw;
        int w, low, rises, busy_cnt, csb_lo, r;
        logic [127:0] bits;
        logic prev;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset pins", {vec_csb, vec_sclk, vec_mosi, reg_csb, reg_sclk, reg_mosi,
                           vec_ack, reg_ack, busy}, 9'b100_100_000);
        reset = 1'b0;
        @(negedge clk);
        chk("idle after reset", {vec_csb, reg_csb, busy}, 3'b110);

        // 1: single vec frame
        vblank = 1'b1;
        vec_data = 74'h2_A5A5_0000_FFFF_1234;
        vec_req = 1'b1;
        wait_ack(10, gv, gr, bz, w);
        chk("t1 ack", {gv, gr, bz}, 3'b101);
        vec_req = 1'b0;
        capture(1'b1, low, rises, bits, ob);
        chk("t1 csb low", low, 298);
        chk("t1 rises", rises, 74);
        chk("t1 bits", bits, 74'h2_A5A5_0000_FFFF_1234);
        chk("t1 reg pins idle", ob, 0);
        chk("t1 busy gap1", busy, 1);
        @(negedge clk);
        chk("t1 busy gap2", busy, 1);
        @(negedge clk);
        chk("t1 busy idle", busy, 0);

        // 2: reg frame of 14 bits
        reg_len = 6'd14;
        reg_data = 32'h0000_2C3B;
        reg_req = 1'b1;
        wait_ack(10, gv, gr, bz, w);
        chk("t2 ack", {gv, gr}, 2'b01);
        reg_req = 1'b0;
        capture(1'b0, low, rises, bits, ob);
        chk("t2 csb low", low, 58);
        chk("t2 rises", rises, 14);
        chk("t2 bits", bits, 14'b10110000111011);
        chk("t2 vec pins idle", ob, 0);
        @(negedge clk);
        @(negedge clk);

        // 3: both held -> alternate starting with vec (last grant was reg)
        vec_data = 74'h1_2345_6789_ABCD_EF01;
        reg_len = 6'd16;
        reg_data = 32'h0000_BEEF;
        vec_req = 1'b1;
        reg_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ack(20, gv, gr, bz, w);
            chk("t3 grant order", {gv, gr}, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i > 0) chk("t3 gap cycles", w, Div);
            if (i == 3) begin
                vec_req = 1'b0;
                reg_req = 1'b0;
            end
            capture(gv, low, rises, bits, ob);
            chk("t3 csb low", low, gv ? 298 : 66);
        end
        @(negedge clk);
        @(negedge clk);

        // 4: vblank gating
        vblank = 1'b0;
        vec_data = 74'h3FF_0123_4567_89AB_CDE;
        vec_req = 1'b1;
        saw = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            #1;
            if (vec_ack || busy) saw = 1'b1;
        end
        chk("t4 gated", saw, 0);
        vblank = 1'b1;
        wait_ack(1, gv, gr, bz, w);
        chk("t4 ack on vblank", gv, 1);
        vec_req = 1'b0;
        vblank = 1'b0;
        capture(1'b1, low, rises, bits, ob);
        chk("t4 rises", rises, 74);
        chk("t4 bits", bits, 74'h3FF_0123_4567_89AB_CDE);
        @(negedge clk);
        @(negedge clk);

        // 5a: zero-length reg frame
        reg_len = 6'd0;
        reg_data = 32'hFFFF_FFFF;
        reg_req = 1'b1;
        wait_ack(10, gv, gr, bz, w);
        chk("t5 zero ack", {gr, bz}, 2'b11);
        reg_req = 1'b0;
        busy_cnt = 0;
        csb_lo = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (!reg_csb) csb_lo++;
        end
        chk("t5 zero busy cycles", busy_cnt + 1, Div + 1);
        chk("t5 zero csb", csb_lo, 0);

        // 5b: reg_len above REG_W is clamped
        reg_len = 6'd40;
        reg_data = 32'hC3A5_0F96;
        reg_req = 1'b1;
        wait_ack(10, gv, gr, bz, w);
        chk("t5 clamp ack", gr, 1);
        reg_req = 1'b0;
        capture(1'b0, low, rises, bits, ob);
        chk("t5 clamp csb low", low, 130);
        chk("t5 clamp rises", rises, 32);
        chk("t5 clamp bits", bits, 32'hC3A5_0F96);
        @(negedge clk);
        @(negedge clk);

        // 6: reset at bit 20 of a vec frame, then a clean frame
        vblank = 1'b1;
        vec_data = 74'h3_FFFF_0000_AAAA_5555_1;
        vec_req = 1'b1;
        wait_ack(10, gv, gr, bz, w);
        chk("t6 ack", gv, 1);
        vec_req = 1'b0;
        r = 0;
        prev = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (r >= 20) break;
            @(negedge clk);
            if (vec_sclk && !prev) r++;
            prev = vec_sclk;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t6 abort idle", {vec_csb, vec_sclk, vec_mosi, busy, reg_csb}, 5'b10001);
        vec_data = 74'h2_0F0F_1234_5678_9ABC;
        vec_req = 1'b1;
        wait_ack(10, gv, gr, bz, w);
        chk("t6 restart ack", gv, 1);
        vec_req = 1'b0;
        capture(1'b1, low, rises, bits, ob);
        chk("t6 restart rises", rises, 74);
        chk("t6 restart bits", bits, 74'h2_0F0F_1234_5678_9ABC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
